// File: rtl/adder_serial_frontend.sv
// Serial operand loader and result unloader around an external WIDTH-bit adder.
// Operands stream in LSB first (A then B); {cout, sum} streams back out LSB first.
module adder_serial_frontend #(
  parameter int WIDTH  = 32,
  parameter int SETTLE = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_ni,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic             cin_i,
  input  logic             sin_i,
  input  logic             sin_valid_i,
  output logic [WIDTH-1:0] op_a_o,
  output logic [WIDTH-1:0] op_b_o,
  output logic             cin_o,
  input  logic [WIDTH-1:0] sum_i,
  input  logic             cout_i,
  output logic             sout_o,
  output logic             sout_valid_o,
  input  logic             sout_ready_i,
  output logic             busy_o,
  output logic             done_o
);

  localparam int CW = $clog2(WIDTH + 2);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD_A = 3'd1;
  localparam logic [2:0] S_LOAD_B = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_SHIFT  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam logic [CW-1:0] LOAD_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] SHIFT_LAST  = CW'(WIDTH);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);

  logic [2:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   res_q;
  logic             cin_q;
  logic             sout_fire;

  assign op_a_o       = a_q;
  assign op_b_o       = b_q;
  assign cin_o        = cin_q;
  assign sout_o       = res_q[0];
  assign sout_valid_o = (state == S_SHIFT);
  assign busy_o       = (state != S_IDLE);
  assign done_o       = (state == S_DONE);
  assign sout_fire    = sout_valid_o & sout_ready_i;

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state <= S_IDLE;
      cnt   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cin_q <= 1'b0;
    end else if (abort_i && state != S_IDLE) begin
      // Abort wins over every other transition; data registers are kept.
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            a_q   <= '0;
            b_q   <= '0;
            cin_q <= cin_i;
            cnt   <= '0;
            state <= S_LOAD_A;
          end
        end
        S_LOAD_A: begin
          if (sin_valid_i) begin
            a_q <= {sin_i, a_q[WIDTH-1:1]};
            if (cnt == LOAD_LAST) begin
              cnt   <= '0;
              state <= S_LOAD_B;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_LOAD_B: begin
          if (sin_valid_i) begin
            b_q <= {sin_i, b_q[WIDTH-1:1]};
            if (cnt == LOAD_LAST) begin
              cnt   <= '0;
              state <= S_SETTLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_SETTLE: begin
          // Operands have been stable since the last B beat; capture after SETTLE cycles.
          if (cnt == SETTLE_LAST) begin
            res_q <= {cout_i, sum_i};
            cnt   <= '0;
            state <= S_SHIFT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_SHIFT: begin
          if (sout_fire) begin
            res_q <= {1'b0, res_q[WIDTH:1]};
            if (cnt == SHIFT_LAST) begin
              cnt   <= '0;
              state <= S_DONE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_DONE: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adder_serial_frontend.sv
// Self-checking bench: behavioural adder, vector table plus scoreboard of serial results.
module tb_adder_serial_frontend;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         start = 1'b0, abort = 1'b0, cin = 1'b0;
  logic         sin = 1'b0, sin_valid = 1'b0, sout_ready = 1'b0;
  logic [W-1:0] op_a, op_b, sum;
  logic         cin_o, cout, sout, sout_valid, busy, done;

  adder_serial_frontend #(.WIDTH(W), .SETTLE(2)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .start_i(start), .abort_i(abort),
    .cin_i(cin), .sin_i(sin), .sin_valid_i(sin_valid),
    .op_a_o(op_a), .op_b_o(op_b), .cin_o(cin_o),
    .sum_i(sum), .cout_i(cout),
    .sout_o(sout), .sout_valid_o(sout_valid), .sout_ready_i(sout_ready),
    .busy_o(busy), .done_o(done)
  );

  // Reference adder standing in for the user-project adder.
  assign {cout, sum} = {1'b0, op_a} + {1'b0, op_b} + {{W{1'b0}}, cin_o};

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    bit           stall;
    bit           bp;
    bit           inj;
    logic [W:0]   exp;
  } vec_t;

  vec_t       vecs[7];
  logic [W:0] exp_q[$];
  logic [W:0] got_q[$];
  int         checks = 0;
  int         errors = 0;
  int         total_beats = 0;
  int         nbits = 0;
  logic [W:0] shreg = '0;

  // Collects accepted serial beats; a reset discards any partial word.
  always @(negedge clk) begin
    if (!rst_n) begin
      nbits = 0;
    end else if (sout_valid && sout_ready) begin
      shreg[nbits] = sout;
      nbits++;
      total_beats++;
      if (nbits == W + 1) begin
        got_q.push_back(shreg);
        nbits = 0;
      end
    end
  end

  task automatic check(input string nm, input logic [W:0] act, input logic [W:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input vec_t v);
    int           idx, cyc, beats0, done_cnt;
    logic [W-1:0] pa, pb;
    logic         hs;
    logic [W:0]   e, g;
    beats0 = total_beats;
    start = 1'b1; cin = v.c;
    tick;
    start = 1'b0; cin = 1'b0;
    check("busy_after_start", {{W{1'b0}}, busy}, 1);
    exp_q.push_back(v.exp);
    idx = 0; cyc = 0;
    while (idx < 2 * W && cyc < 1000) begin
      sin_valid = v.stall ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      sin = (idx < W) ? v.a[idx] : v.b[idx-W];
      start = v.inj && (idx == W + 5);
      pa = op_a; pb = op_b;
      tick;
      start = 1'b0;
      if (sin_valid) idx++;
      else begin
        check("stall_hold_a", {1'b0, op_a}, {1'b0, pa});
        check("stall_hold_b", {1'b0, op_b}, {1'b0, pb});
      end
      cyc++;
    end
    sin_valid = 1'b0;
    if (cyc >= 1000) check("load_timeout", 1, 0);
    check("op_a", {1'b0, op_a}, {1'b0, v.a});
    check("op_b", {1'b0, op_b}, {1'b0, v.b});
    check("cin_o", {{W{1'b0}}, cin_o}, {{W{1'b0}}, v.c});
    check("settle0_valid", {{W{1'b0}}, sout_valid}, 0);
    tick;
    check("settle1_valid", {{W{1'b0}}, sout_valid}, 0);
    tick;
    check("capture_valid", {{W{1'b0}}, sout_valid}, 1);
    cyc = 0; done_cnt = 0; hs = 1'b0;
    while (busy && cyc < 300) begin
      sout_ready = !(v.bp && cyc >= 10 && cyc < 15);
      start = v.inj && (cyc == 3);
      if (v.bp && cyc == 10) hs = sout;
      if (v.bp && cyc == 14) begin
        check("bp_hold_bit", {{W{1'b0}}, sout}, {{W{1'b0}}, hs});
        check("bp_hold_valid", {{W{1'b0}}, sout_valid}, 1);
      end
      tick;
      start = 1'b0;
      if (done) done_cnt++;
      cyc++;
    end
    sout_ready = 1'b0;
    if (cyc >= 300) check("shift_timeout", 1, 0);
    check("done_once", done_cnt, 1);
    check("idle_after_done", {{W{1'b0}}, busy}, 0);
    check("done_low_after", {{W{1'b0}}, done}, 0);
    check("beat_count", total_beats - beats0, W + 1);
    if (got_q.size() == 0 || exp_q.size() == 0) begin
      check("result_missing", 0, 1);
    end else begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      $display("txn a=%h b=%h cin=%0d result=%h", v.a, v.b, v.c, g);
      check("serial_result", g, e);
    end
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_sout"}, {{W{1'b0}}, sout}, 0);
    check({nm, "_valid"}, {{W{1'b0}}, sout_valid}, 0);
    check({nm, "_busy"}, {{W{1'b0}}, busy}, 0);
    check({nm, "_done"}, {{W{1'b0}}, done}, 0);
    check({nm, "_op_a"}, {1'b0, op_a}, 0);
    check({nm, "_op_b"}, {1'b0, op_b}, 0);
    check({nm, "_cin"}, {{W{1'b0}}, cin_o}, 0);
  endtask

  initial begin
    int   beats0;
    vec_t v;
    vecs[0] = '{a: 32'hFFFFFFFF, b: 32'h00000001, c: 1'b0, stall: 0, bp: 0, inj: 0, exp: 33'h1_0000_0000};
    vecs[1] = '{a: 32'h12345678, b: 32'h0FEDCBA9, c: 1'b1, stall: 0, bp: 0, inj: 0, exp: 33'h0_2222_2222};
    vecs[2] = '{a: 32'h12345678, b: 32'h0FEDCBA9, c: 1'b1, stall: 1, bp: 0, inj: 0, exp: 33'h0_2222_2222};
    vecs[3] = '{a: 32'h12345678, b: 32'h0FEDCBA9, c: 1'b1, stall: 0, bp: 1, inj: 0, exp: 33'h0_2222_2222};
    vecs[4] = '{a: 32'h80000000, b: 32'h80000000, c: 1'b0, stall: 0, bp: 0, inj: 1, exp: 33'h1_0000_0000};
    vecs[5] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, c: 1'b1, stall: 1, bp: 1, inj: 0, exp: 33'h1_FFFF_FFFF};
    vecs[6] = '{a: 32'h00000000, b: 32'h00000000, c: 1'b0, stall: 0, bp: 0, inj: 0, exp: 33'h0_0000_0000};

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick;

    for (int i = 0; i < 7; i++) run_txn(vecs[i]);

    // Abort after 10 A bits: idle next cycle, nothing emitted.
    beats0 = total_beats;
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sin_valid = 1'b1; sin = i[0];
      tick;
    end
    abort = 1'b1; tick; abort = 1'b0;
    check("abort_idle", {{W{1'b0}}, busy}, 0);
    repeat (40) tick;
    sin_valid = 1'b0;
    check("abort_no_beats", total_beats - beats0, 0);
    check("abort_no_result", got_q.size(), 0);

    // Abort and start together in LOAD_A.
    start = 1'b1; tick; start = 1'b0;
    sin_valid = 1'b1; repeat (3) tick; sin_valid = 1'b0;
    abort = 1'b1; start = 1'b1; tick; abort = 1'b0; start = 1'b0;
    check("abort_start_idle", {{W{1'b0}}, busy}, 0);
    tick;
    check("abort_start_stays_idle", {{W{1'b0}}, busy}, 0);

    // Asynchronous reset in the middle of SHIFT.
    start = 1'b1; tick; start = 1'b0;
    for (int i = 0; i < 2 * W; i++) begin
      sin_valid = 1'b1; sin = (i % 3 == 0);
      tick;
    end
    sin_valid = 1'b0;
    repeat (2) tick;
    check("pre_reset_valid", {{W{1'b0}}, sout_valid}, 1);
    sout_ready = 1'b1;
    repeat (5) tick;
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("midshift_reset");
    sout_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick;
    check("no_partial_result", got_q.size(), 0);
    v = '{a: 32'd5, b: 32'd3, c: 1'b0, stall: 0, bp: 0, inj: 0, exp: 33'h0_0000_0008};
    run_txn(v);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end
endmodule
